// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract sequencer that time-shares one external 4-bit adder slice.
// Operands are walked LSB nibble first, with the slice carry-out registered as the next carry-in.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [WIDTH-1:0] w_accNext;
    logic             w_ovf;

    // Present the current nibble to the slice only while running; idle slice inputs stay quiet.
    always_comb begin
        slice_a   = 4'd0;
        slice_b   = 4'd0;
        slice_cin = 1'b0;
        w_accNext = r_acc;
        if (r_state == RUN) begin
            slice_cin = r_c;
            for (int n = 0; n < NIB; n++) begin
                if (r_idx == IDXW'(n)) begin
                    slice_a            = r_a[4*n +: 4];
                    slice_b            = r_b[4*n +: 4];
                    w_accNext[4*n +: 4] = slice_sum;
                end
            end
        end
    end

    assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (slice_sum[3] != r_a[WIDTH-1]);

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

    // Subtraction is a + ~b + 1, so the inversion and forced carry happen once at capture time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_c     <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc <= w_accNext;
                    r_c   <= slice_cout;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_state <= DONE;
                        r_sum   <= w_accNext;
                        r_cout  <= slice_cout;
                        r_ovf   <= w_ovf;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl: directed scenarios plus randomized operations
// compared against a whole-word arithmetic reference model.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_cin;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int nCompared   = 0;
    int nMismatched = 0;

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_cin (slice_cin),
        .slice_sum (slice_sum),
        .slice_cout(slice_cout),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Behavioural model of the shared 4-bit adder slice.
    assign {slice_cout, slice_sum} = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-word reference: returns {cout, ovf, sum}.
    function automatic logic [WIDTH+1:0] refModel(input logic s, input logic [WIDTH-1:0] av,
                                                  input logic [WIDTH-1:0] bv, input logic c);
        logic [WIDTH-1:0] bEff;
        logic [WIDTH:0]   full;
        logic             o;
        bEff = s ? ~bv : bv;
        full = {1'b0, av} + {1'b0, bEff} + {{WIDTH{1'b0}}, (s ? 1'b1 : c)};
        o    = (av[WIDTH-1] == bEff[WIDTH-1]) && (full[WIDTH-1] != av[WIDTH-1]);
        return {full[WIDTH], o, full[WIDTH-1:0]};
    endfunction

    // Issues one operation and waits (bounded) for done; lat counts edges from accept to done.
    task automatic doOp(input logic s, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic c, output int lat, output int busyCnt,
                        output logic [NIB-1:0] cinTrace, output bit ok);
        @(negedge clk);
        start = 1'b1; sub = s; a = av; b = bv; cin = c;
        @(posedge clk);
        lat = 0; busyCnt = 0; ok = 1'b0; cinTrace = '0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            lat = i;
            if (busy) begin
                if (busyCnt < NIB) cinTrace[busyCnt] = slice_cin;
                busyCnt++;
            end
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        nCompared++;
        if ({busy, done, cout, ovf, sum, slice_a, slice_b, slice_cin} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_state: busy=%b done=%b cout=%b ovf=%b sum=%h sa=%h sb=%h sc=%b, want all 0",
                     busy, done, cout, ovf, sum, slice_a, slice_b, slice_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nCompared++;
        if ({busy, done, slice_a, slice_b, slice_cin} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL idle_after_reset: busy=%b done=%b sa=%h sb=%h sc=%b, want 0",
                     busy, done, slice_a, slice_b, slice_cin);
        end
    endtask

    task automatic test_add_basic();
        int lat, bc; logic [NIB-1:0] tr; bit ok;
        doOp(1'b0, 16'h1234, 16'h4321, 1'b0, lat, bc, tr, ok);
        nCompared++;
        if (!ok || lat != NIB || bc != NIB) begin
            nMismatched++;
            $display("[TB] FAIL add_latency: ok=%0d lat=%0d busy=%0d, want ok=1 lat=%0d busy=%0d",
                     ok, lat, bc, NIB, NIB);
        end
        nCompared++;
        if ({cout, ovf, sum} !== {1'b0, 1'b0, 16'h5555}) begin
            nMismatched++;
            $display("[TB] FAIL add_basic: got c=%b o=%b s=%h, want c=0 o=0 s=5555", cout, ovf, sum);
        end
        @(negedge clk);
        nCompared++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL done_one_cycle: done=%b busy=%b after pulse, want 0 0", done, busy);
        end
    endtask

    task automatic test_ripple();
        int lat, bc; logic [NIB-1:0] tr; bit ok;
        doOp(1'b0, 16'hFFFF, 16'h0001, 1'b0, lat, bc, tr, ok);
        nCompared++;
        if (!ok || {cout, ovf, sum} !== {1'b1, 1'b0, 16'h0000}) begin
            nMismatched++;
            $display("[TB] FAIL ripple_result: ok=%0d c=%b o=%b s=%h, want c=1 o=0 s=0000", ok, cout, ovf, sum);
        end
        nCompared++;
        if (tr !== 4'b1110) begin
            nMismatched++;
            $display("[TB] FAIL ripple_slice_cin: trace=%b, want 1110 (step0 first)", tr);
        end
    endtask

    task automatic test_sub();
        int lat, bc; logic [NIB-1:0] tr; bit ok;
        doOp(1'b1, 16'h0005, 16'h0007, 1'b1, lat, bc, tr, ok);
        nCompared++;
        if (!ok || {cout, ovf, sum} !== {1'b0, 1'b0, 16'hFFFE}) begin
            nMismatched++;
            $display("[TB] FAIL sub_borrow: ok=%0d c=%b o=%b s=%h, want c=0 o=0 s=fffe", ok, cout, ovf, sum);
        end
        doOp(1'b1, 16'h8000, 16'h0001, 1'b0, lat, bc, tr, ok);
        nCompared++;
        if (!ok || {cout, ovf, sum} !== {1'b1, 1'b1, 16'h7FFF}) begin
            nMismatched++;
            $display("[TB] FAIL sub_overflow: ok=%0d c=%b o=%b s=%h, want c=1 o=1 s=7fff", ok, cout, ovf, sum);
        end
    endtask

    task automatic test_start_while_busy();
        int doneAt = -1;
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 16'h7FFF; b = 16'h0001; cin = 1'b0;
        @(posedge clk);
        for (int i = 0; i <= NIB + 1; i++) begin
            @(negedge clk);
            start = (i == 2);
            if (i == 2) begin sub = 1'b1; a = 16'hAAAA; b = 16'h1111; cin = 1'b1; end
            if (done && doneAt < 0) doneAt = i;
        end
        start = 1'b0;
        nCompared++;
        if (doneAt != NIB || {ovf, sum} !== {1'b1, 16'h8000}) begin
            nMismatched++;
            $display("[TB] FAIL ignore_start: doneAt=%0d o=%b s=%h, want doneAt=%0d o=1 s=8000",
                     doneAt, ovf, sum, NIB);
        end
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL ignore_start_no_restart: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc; logic [NIB-1:0] tr; bit ok;
        int doneAt = -1;
        bit held = 1'b1;
        doOp(1'b0, 16'h1000, 16'h0234, 1'b1, lat, bc, tr, ok);
        start = 1'b1; sub = 1'b0; a = 16'h0001; b = 16'h0002; cin = 1'b0;
        @(posedge clk);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j == 0) begin
                nCompared++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    nMismatched++;
                    $display("[TB] FAIL b2b_first_done_pulse: done=%b busy=%b, want 0 1", done, busy);
                end
            end
            if (done) begin doneAt = j; break; end
            if (sum !== 16'h1235) held = 1'b0;
        end
        nCompared++;
        if (!ok || !held) begin
            nMismatched++;
            $display("[TB] FAIL b2b_hold: ok=%0d held=%0d, want first result 1235 held until second done", ok, held);
        end
        nCompared++;
        if (doneAt != NIB || sum !== 16'h0003) begin
            nMismatched++;
            $display("[TB] FAIL b2b_second: doneAt=%0d s=%h, want doneAt=%0d s=0003", doneAt, sum, NIB);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc; logic [NIB-1:0] tr; bit ok;
        bit sawDone = 1'b0;
        @(negedge clk);
        start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nCompared++;
        if ({busy, done, cout, ovf, sum, slice_a, slice_b, slice_cin} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset: busy=%b done=%b sum=%h sa=%h sb=%h sc=%b, want 0",
                     busy, done, sum, slice_a, slice_b, slice_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NIB + 2; i++) begin
            @(negedge clk);
            if (done || busy) sawDone = 1'b1;
        end
        nCompared++;
        if (sawDone) begin
            nMismatched++;
            $display("[TB] FAIL reset_abort: done/busy seen after reset=1, want 0");
        end
        doOp(1'b0, 16'h00FF, 16'h0001, 1'b0, lat, bc, tr, ok);
        nCompared++;
        if (!ok || sum !== 16'h0100) begin
            nMismatched++;
            $display("[TB] FAIL after_reset_add: ok=%0d s=%h, want s=0100", ok, sum);
        end
    endtask

    task automatic test_random();
        int lat, bc; logic [NIB-1:0] tr; bit ok;
        logic s, c;
        logic [WIDTH-1:0] av, bv;
        logic [WIDTH+1:0] exp;
        for (int n = 0; n < 40; n++) begin
            s  = 1'($urandom);
            c  = 1'($urandom);
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            if (n < 4) av = {1'b0, {(WIDTH-1){1'b1}}};
            exp = refModel(s, av, bv, c);
            doOp(s, av, bv, c, lat, bc, tr, ok);
            nCompared++;
            if (!ok || lat != NIB || {cout, ovf, sum} !== exp) begin
                nMismatched++;
                $display("[TB] FAIL random[%0d]: sub=%b a=%h b=%h cin=%b ok=%0d lat=%0d got c=%b o=%b s=%h, want lat=%0d c=%b o=%b s=%h",
                         n, s, av, bv, c, ok, lat, cout, ovf, sum, NIB,
                         exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_ripple();
        test_sub();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
